// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the RX and TX halves of the SoC UART.
// Holds the receiver state encoding, default timing/depth constants and the RX register address.
package uart_pkg;

  localparam int UART_CLOCKS_PER_BIT = 104;
  localparam int UART_FIFO_DEPTH     = 16;

  // CPU-visible address of the RX data register.
  localparam logic [15:0] UART_RX_REG_ADDR = 16'd1032;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separately tracked occupancy count; the head entry is presented combinationally.
// Shared by the UART RX and TX byte queues.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees the slot that a push into a full FIFO needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive path: 8N1 deserialiser feeding a byte FIFO, with a one-pop-per-ack CPU handshake
// and sticky overflow / framing-error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT,
  parameter int RX_FIFO        = UART_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     uart_rx,
  input  logic                     rx_pop,
  output logic [7:0]               rx_data,
  output logic                     rx_ack,
  output logic [$clog2(RX_FIFO):0] rx_count,
  output logic                     rx_overflow,
  output logic                     rx_frame_err,
  input  logic                     err_clear
);

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLOCKS_PER_BIT / 2 - 1);

  uart_state_e state;
  uart_state_e state_next;

  logic          sync_q;
  logic          rx_s;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          push_pending;

  logic half_done;
  logic bit_done;
  logic timer_clear;
  logic data_enter;
  logic sample_bit;
  logic stop_ok;
  logic frame_evt;

  logic       accept;
  logic       overflow_evt;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;

  // Both synchroniser flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= uart_rx;
      rx_s   <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign half_done = (state == START) && (timer == HALF_LAST);
  assign bit_done  = (timer == BIT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!rx_s) state_next = START;
      START:   if (half_done) state_next = rx_s ? IDLE : DATA;
      DATA:    if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
      STOP:    if (bit_done) state_next = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The single bit timer is held at zero whenever it is not timing a bit, so every phase starts from 0.
  always_comb begin
    timer_clear = 1'b0;
    data_enter  = 1'b0;
    sample_bit  = 1'b0;
    stop_ok     = 1'b0;
    frame_evt   = 1'b0;
    case (state)
      IDLE:  timer_clear = 1'b1;
      START: begin
        timer_clear = half_done;
        data_enter  = half_done && !rx_s;
      end
      DATA: begin
        timer_clear = bit_done;
        sample_bit  = bit_done;
      end
      STOP: begin
        timer_clear = bit_done;
        stop_ok     = bit_done && rx_s;
        frame_evt   = bit_done && !rx_s;
      end
      BREAK:   timer_clear = 1'b1;
      default: timer_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer        <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      push_pending <= 1'b0;
    end else begin
      if (timer_clear) timer <= '0;
      else             timer <= timer + TIMER_ONE;
      if (data_enter)      bit_idx <= '0;
      else if (sample_bit) bit_idx <= bit_idx + 3'd1;
      if (sample_bit) shift[bit_idx] <= rx_s;
      push_pending <= stop_ok;
    end
  end

  // rx_ack low is part of the accept condition, so a pop held through the ack cycle cannot double-pop.
  assign accept       = rx_pop && !fifo_empty && !rx_ack;
  assign overflow_evt = push_pending && fifo_full && !accept;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_pending),
    .push_data (shift),
    .pop       (accept),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rx_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ack  <= 1'b0;
      rx_data <= '0;
    end else begin
      rx_ack <= accept;
      if (accept) rx_data <= fifo_head;
    end
  end

  // A clear wins over an event in the same cycle; that event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else if (err_clear) begin
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (overflow_evt) rx_overflow  <= 1'b1;
      if (frame_evt)    rx_frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven frames, hand-written corner sequences,
// and randomized frames checked against a queue-based model of the receiver.
module tb_uart_rx_fifo;

  localparam int CPB   = 104;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int HALF  = CPB / 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          uart_rx;
  logic          rx_pop;
  logic          err_clear;
  logic [7:0]    rx_data;
  logic          rx_ack;
  logic [CW-1:0] rx_count;
  logic          rx_overflow;
  logic          rx_frame_err;

  int total = 0;
  int bad   = 0;

  int            cycleNum  = 0;
  int            ackCount  = 0;
  int            ackCycle  = -1;
  int            pushCycle = -1;
  logic [7:0]    lastAck   = '0;
  logic [CW-1:0] prevCount = '0;

  typedef struct {
    logic [7:0] data;
    bit         stopBit;
    bit         popAfter;
    logic [7:0] expPop;
    int         expCount;
    bit         expFerr;
  } vec_t;

  vec_t vecs [6];

  uart_rx_fifo #(
    .CLOCKS_PER_BIT (CPB),
    .RX_FIFO        (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx      (uart_rx),
    .rx_pop       (rx_pop),
    .rx_data      (rx_data),
    .rx_ack       (rx_ack),
    .rx_count     (rx_count),
    .rx_overflow  (rx_overflow),
    .rx_frame_err (rx_frame_err),
    .err_clear    (err_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  always @(negedge clk) begin
    if (rst_n && rx_ack) begin
      ackCount <= ackCount + 1;
      lastAck  <= rx_data;
      ackCycle <= cycleNum;
    end
    if (rst_n && (prevCount == '0) && (rx_count != '0)) pushCycle <= cycleNum;
    prevCount <= rx_count;
  end

  initial begin
    #(1500000 * 10);
    $display("[TB] FAIL watchdog: simulation still running after time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic sendFrame(input logic [7:0] d, input bit stopBit);
    uart_rx = 1'b0;
    waitCycles(CPB);
    for (int b = 0; b < 8; b++) begin
      uart_rx = d[b];
      waitCycles(CPB);
    end
    uart_rx = stopBit;
    waitCycles(CPB);
  endtask

  task automatic doPop(input logic [7:0] expected, input string name);
    bit seen;
    seen   = 1'b0;
    rx_pop = 1'b1;
    for (int k = 0; k < 50 && !seen; k++) begin
      waitCycles(1);
      if (rx_ack === 1'b1) seen = 1'b1;
    end
    rx_pop = 1'b0;
    checkOutput($sformatf("%s ack", name), 32'(seen), 1);
    checkOutput($sformatf("%s data", name), rx_data, expected);
    waitCycles(1);
    checkOutput($sformatf("%s ack one cycle", name), rx_ack, 0);
  endtask

  task automatic pulseClear();
    err_clear = 1'b1;
    waitCycles(1);
    err_clear = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    sendFrame(v.data, v.stopBit);
    if (!v.stopBit) begin
      waitCycles(CPB);
      uart_rx = 1'b1;
      waitCycles(2 * CPB);
    end
    waitCycles(4);
    if (v.popAfter) doPop(v.expPop, $sformatf("vec%0d pop", idx));
    checkOutput($sformatf("vec%0d rx_count", idx), rx_count, v.expCount);
    checkOutput($sformatf("vec%0d frame_err", idx), rx_frame_err, v.expFerr);
    checkOutput($sformatf("vec%0d overflow", idx), rx_overflow, 0);
  endtask

  initial begin
    int         pushLat;
    int         ackBefore;
    logic [7:0] q [$];
    bit         mOvf;
    bit         mFerr;
    logic [7:0] d;
    bit         st;
    int         np;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0, 1'b0};
    vecs[1] = '{8'hC3, 1'b1, 1'b0, 8'h00, 1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 8'h00, 1, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hC3, 1, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 8'hFF, 1, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h01, 1, 1'b1};

    rst_n     = 1'b0;
    uart_rx   = 1'b1;
    rx_pop    = 1'b0;
    err_clear = 1'b0;
    waitCycles(5);
    checkOutput("reset rx_ack", rx_ack, 0);
    checkOutput("reset rx_data", rx_data, 0);
    checkOutput("reset rx_count", rx_count, 0);
    checkOutput("reset overflow", rx_overflow, 0);
    checkOutput("reset frame_err", rx_frame_err, 0);
    rst_n = 1'b1;
    waitCycles(5);
    checkOutput("idle rx_count", rx_count, 0);

    // 0xA5 with no pop; also measures frame-start-to-count latency for the aligned tests
    pushLat = 0;
    fork
      sendFrame(8'hA5, 1'b1);
      begin
        for (int k = 1; k <= 11 * CPB && pushLat == 0; k++) begin
          waitCycles(1);
          if (rx_count == CW'(1)) pushLat = k;
        end
      end
    join
    checkOutput("push latency in range", 32'((pushLat >= 9 * CPB + HALF) && (pushLat <= 9 * CPB + HALF + 6)), 1);
    if (pushLat < 3) pushLat = 9 * CPB + HALF + 4;
    waitCycles(4);
    checkOutput("A5 rx_count", rx_count, 1);
    doPop(8'hA5, "A5 pop");
    checkOutput("A5 rx_count after pop", rx_count, 0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);
    doPop(8'h80, "table drain");
    pulseClear();
    checkOutput("table frame_err cleared", rx_frame_err, 0);
    checkOutput("table rx_count empty", rx_count, 0);

    // pop held on an empty FIFO: one ack, one cycle after the push
    rx_pop    = 1'b1;
    ackBefore = ackCount;
    waitCycles(20);
    checkOutput("stall no ack", 32'(ackCount - ackBefore), 0);
    sendFrame(8'h3C, 1'b1);
    waitCycles(4);
    checkOutput("stall ack count", 32'(ackCount - ackBefore), 1);
    checkOutput("stall ack data", lastAck, 8'h3C);
    checkOutput("stall ack latency", 32'(ackCycle - pushCycle), 1);
    waitCycles(300);
    checkOutput("stall no second ack", 32'(ackCount - ackBefore), 1);
    checkOutput("stall rx_count", rx_count, 0);
    rx_pop = 1'b0;
    waitCycles(2);

    // fill past depth: the 17th byte is dropped
    for (int i = 0; i <= DEPTH; i++) sendFrame(8'(i), 1'b1);
    waitCycles(4);
    checkOutput("full rx_count", rx_count, DEPTH);
    checkOutput("full overflow", rx_overflow, 1);
    checkOutput("full frame_err", rx_frame_err, 0);
    pulseClear();
    checkOutput("overflow cleared", rx_overflow, 0);

    // push into a full FIFO in the same cycle as an accepted pop
    ackBefore = ackCount;
    fork
      sendFrame(8'h11, 1'b1);
      begin
        waitCycles(pushLat - 1);
        rx_pop = 1'b1;
        waitCycles(1);
        rx_pop = 1'b0;
      end
    join
    waitCycles(4);
    checkOutput("full+pop ack count", 32'(ackCount - ackBefore), 1);
    checkOutput("full+pop ack data", lastAck, 8'h00);
    checkOutput("full+pop rx_count", rx_count, DEPTH);
    checkOutput("full+pop overflow", rx_overflow, 0);
    for (int i = 1; i < DEPTH; i++) doPop(8'(i), $sformatf("drain %0d", i));
    doPop(8'h11, "drain last");
    checkOutput("drain rx_count", rx_count, 0);

    // short low glitch on an idle line
    ackBefore = ackCount;
    uart_rx   = 1'b0;
    waitCycles(30);
    uart_rx = 1'b1;
    waitCycles(200);
    checkOutput("glitch rx_count", rx_count, 0);
    checkOutput("glitch overflow", rx_overflow, 0);
    checkOutput("glitch frame_err", rx_frame_err, 0);
    checkOutput("glitch no ack", 32'(ackCount - ackBefore), 0);
    sendFrame(8'h55, 1'b1);
    waitCycles(4);
    checkOutput("55 rx_count", rx_count, 1);
    doPop(8'h55, "55 pop");

    // stop bit low, then the line held low: one error event only
    sendFrame(8'h81, 1'b0);
    waitCycles(2000);
    checkOutput("break frame_err", rx_frame_err, 1);
    checkOutput("break rx_count", rx_count, 0);
    pulseClear();
    waitCycles(1500);
    checkOutput("break single event", rx_frame_err, 0);
    checkOutput("break rx_count held", rx_count, 0);
    uart_rx = 1'b1;
    waitCycles(2 * CPB);
    sendFrame(8'h7E, 1'b1);
    waitCycles(4);
    checkOutput("7E rx_count", rx_count, 1);
    checkOutput("7E frame_err", rx_frame_err, 0);
    doPop(8'h7E, "7E pop");

    // clear in the same cycle as a framing error: the event is lost
    fork
      sendFrame(8'h00, 1'b0);
      begin
        waitCycles(pushLat - 2);
        err_clear = 1'b1;
        waitCycles(1);
        err_clear = 1'b0;
      end
    join
    waitCycles(CPB);
    uart_rx = 1'b1;
    waitCycles(2 * CPB);
    checkOutput("clear priority frame_err", rx_frame_err, 0);
    sendFrame(8'h00, 1'b0);
    waitCycles(CPB);
    uart_rx = 1'b1;
    waitCycles(2 * CPB);
    checkOutput("unmasked frame_err", rx_frame_err, 1);
    checkOutput("frame_err rx_count", rx_count, 0);

    // reset during bit 4 of a frame
    sendFrame(8'h5A, 1'b1);
    waitCycles(4);
    checkOutput("pre-reset rx_count", rx_count, 1);
    fork
      sendFrame(8'hF0, 1'b1);
      begin
        waitCycles(5 * CPB + HALF);
        rst_n = 1'b0;
        #1;
        checkOutput("midframe reset rx_count", rx_count, 0);
        checkOutput("midframe reset rx_data", rx_data, 0);
        checkOutput("midframe reset rx_ack", rx_ack, 0);
        checkOutput("midframe reset overflow", rx_overflow, 0);
        checkOutput("midframe reset frame_err", rx_frame_err, 0);
        waitCycles(3);
        rst_n = 1'b1;
      end
    join
    waitCycles(2 * CPB);
    checkOutput("post-reset rx_count", rx_count, 0);
    checkOutput("post-reset frame_err", rx_frame_err, 0);
    sendFrame(8'h12, 1'b1);
    waitCycles(4);
    checkOutput("12 rx_count", rx_count, 1);
    doPop(8'h12, "12 pop");

    // randomized frames against a queue model
    mOvf  = 1'b0;
    mFerr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 6) != 0);
      waitCycles($urandom_range(0, CPB));
      sendFrame(d, st);
      if (!st) begin
        waitCycles($urandom_range(CPB, 3 * CPB));
        uart_rx = 1'b1;
        waitCycles(2 * CPB);
        mFerr = 1'b1;
      end else if (q.size() < DEPTH) begin
        q.push_back(d);
      end else begin
        mOvf = 1'b1;
      end
      waitCycles(4);
      checkOutput($sformatf("rand%0d rx_count", i), rx_count, q.size());
      checkOutput($sformatf("rand%0d overflow", i), rx_overflow, mOvf);
      checkOutput($sformatf("rand%0d frame_err", i), rx_frame_err, mFerr);
      np = $urandom_range(0, 2);
      for (int j = 0; j < np; j++) begin
        if (q.size() > 0) doPop(q.pop_front(), $sformatf("rand%0d pop%0d", i, j));
      end
      if ($urandom_range(0, 3) == 0) begin
        pulseClear();
        mOvf  = 1'b0;
        mFerr = 1'b0;
      end
    end
    while (q.size() > 0) doPop(q.pop_front(), "rand drain");
    checkOutput("rand final rx_count", rx_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
